// File: rtl/dpram_responder_pkg.sv
// Shared definitions for the DPRAM responder: default geometry, FSM states,
// and request decoding used by both the RTL and the initiator-side bench.
package dpram_responder_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 10;
  localparam int unsigned DATA_W_DEFAULT = 16;

  // Responder FSM states.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWrite   = 3'd1,
    StRdWait  = 3'd2,
    StRdLatch = 3'd3,
    StDone    = 3'd4
  } state_e;

  // Classification of the RD/WR request pair sampled in idle.
  typedef enum logic [1:0] {
    ReqNone    = 2'd0,
    ReqRead    = 2'd1,
    ReqWrite   = 2'd2,
    ReqIllegal = 2'd3
  } req_e;

  function automatic req_e decode_req(input logic rd, input logic wr);
    req_e req;
    case ({rd, wr})
      2'b10:   req = ReqRead;
      2'b01:   req = ReqWrite;
      2'b11:   req = ReqIllegal;
      default: req = ReqNone;
    endcase
    return req;
  endfunction

  // True while the initiator still holds any request line.
  function automatic logic req_active(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/dpram_responder_if.sv
// Initiator/responder bus for the DPRAM responder: four-phase RD/WR request
// with registered Done/Err/DOut and a Busy status.
interface dpram_responder_if
  import dpram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) ();

  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] DIn;
  logic              RD;
  logic              WR;
  logic [DATA_W-1:0] DOut;
  logic              Done;
  logic              Err;
  logic              Busy;

  modport master (
    output A, DIn, RD, WR,
    input  DOut, Done, Err, Busy
  );

  modport slave (
    input  A, DIn, RD, WR,
    output DOut, Done, Err, Busy
  );

endinterface

// File: rtl/dpram_array.sv
// Single-clock synchronous RAM: one write port, one registered read port
// (one cycle of read latency). Contents are never reset.
module dpram_array
  import dpram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  // Write port and registered read port; read-during-write returns old data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dpram_responder.sv
// DPRAM responder: accepts one four-phase RD/WR request at a time, performs it
// against the internal RAM using only values latched in idle, and reports
// completion on Done (and illegal RD+WR requests on Err).
module dpram_responder
  import dpram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input logic               clk,
  input logic               ar,
  dpram_responder_if.slave  bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              we_q;
  logic [DATA_W-1:0] dout_q;
  logic              done_q;
  logic              err_q;
  logic              busy_q;
  logic [DATA_W-1:0] ram_rdata;
  req_e              req;

  assign req = decode_req(bus.RD, bus.WR);

  // The RAM only ever sees the latched address; the live bus address is
  // ignored once a request has been accepted.
  dpram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (we_q),
    .waddr (addr_q),
    .wdata (data_q),
    .raddr (addr_q),
    .rdata (ram_rdata)
  );

  // Request FSM with all bus-visible outputs registered alongside the state.
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // Write enable is a single-cycle pulse covering the WRITE state only.
      we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          unique case (req)
            ReqWrite: begin
              state_q <= StWrite;
              addr_q  <= bus.A;
              data_q  <= bus.DIn;
              we_q    <= 1'b1;
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
            ReqRead: begin
              state_q <= StRdWait;
              addr_q  <= bus.A;
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
            ReqIllegal: begin
              // No RAM access and DOut untouched; just flag and complete.
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
            default: ;
          endcase
        end
        StWrite: begin
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        StRdWait: begin
          // RAM is registering mem[addr_q] on this edge.
          state_q <= StRdLatch;
        end
        StRdLatch: begin
          dout_q  <= ram_rdata;
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        StDone: begin
          // Hold Done until the initiator has released both request lines.
          if (!req_active(bus.RD, bus.WR)) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.DOut = dout_q;
  assign bus.Done = done_q;
  assign bus.Err  = err_q;
  assign bus.Busy = busy_q;

endmodule

// File: tb/tb_dpram_responder.sv
// Initiator-side bench for dpram_responder: directed scenarios plus a
// randomized run checked against a word-level memory model.
module tb_dpram_responder;
  import dpram_responder_pkg::*;

  localparam int unsigned AW = ADDR_W_DEFAULT;
  localparam int unsigned DW = DATA_W_DEFAULT;
  localparam int Bound = 16;

  logic clk = 1'b0;
  logic ar  = 1'b1;

  always #5 clk = ~clk;

  dpram_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dpram_responder #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk (clk),
    .ar  (ar),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: RAM words written so far, last read value, error flag.
  logic [DW-1:0] mem_m [int];
  logic [DW-1:0] dout_m;
  logic          err_m;

  // Full four-phase transaction; returns observed latencies and outputs.
  task automatic access(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat, output logic [DW-1:0] dout,
                        output logic err, output int rel_lat, output logic busy_idle);
    @(negedge clk);
    bus.RD = rd; bus.WR = wr; bus.A = a; bus.DIn = d;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (bus.Done !== 1'b1 && lat < Bound);
    dout = bus.DOut;
    err  = bus.Err;
    @(negedge clk);
    bus.RD = 1'b0; bus.WR = 1'b0; bus.A = AW'($urandom); bus.DIn = DW'($urandom);
    rel_lat = 0;
    do begin
      @(posedge clk); #1; rel_lat++;
    end while (bus.Done !== 1'b0 && rel_lat < Bound);
    busy_idle = bus.Busy;
    if (rd && wr) begin
      err_m = 1'b1;
    end else if (wr) begin
      mem_m[int'(a)] = d;
      err_m = 1'b0;
    end else if (rd) begin
      dout_m = mem_m.exists(int'(a)) ? mem_m[int'(a)] : 'x;
      err_m = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.RD = 1'b0; bus.WR = 1'b0; bus.A = '0; bus.DIn = '0;
    #1 ar = 1'b0;
    #2;
    tests++; if (bus.DOut !== '0) begin fails++; $display("FAIL reset_dout got %h want 0", bus.DOut); end
    tests++; if (bus.Done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.Done); end
    tests++; if (bus.Err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", bus.Err); end
    tests++; if (bus.Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
    dout_m = '0; err_m = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) ar = 1'b1;
  endtask

  task automatic test_write_read();
    int lat, rl; logic [DW-1:0] dout; logic err, bi;
    access(1'b0, 1'b1, 10'h005, 16'hBEEF, lat, dout, err, rl, bi);
    tests++; if (lat !== 2) begin fails++; $display("FAIL wr_latency got %0d want 2", lat); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL wr_err got %b want 0", err); end
    tests++; if (rl !== 1 || bi !== 1'b0) begin fails++; $display("FAIL wr_release got %0d/%b want 1/0", rl, bi); end
    access(1'b1, 1'b0, 10'h005, 16'h0000, lat, dout, err, rl, bi);
    tests++; if (lat !== 3) begin fails++; $display("FAIL rd_latency got %0d want 3", lat); end
    tests++; if (dout !== 16'hBEEF) begin fails++; $display("FAIL rd_data got %h want beef", dout); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rd_err got %b want 0", err); end
  endtask

  task automatic test_illegal();
    int lat, rl; logic [DW-1:0] dout; logic err, bi;
    access(1'b0, 1'b1, 10'h010, 16'h5A5A, lat, dout, err, rl, bi);
    access(1'b1, 1'b0, 10'h005, 16'h0000, lat, dout, err, rl, bi);
    access(1'b1, 1'b1, 10'h010, 16'hFFFF, lat, dout, err, rl, bi);
    tests++; if (lat !== 1) begin fails++; $display("FAIL ill_latency got %0d want 1", lat); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL ill_err got %b want 1", err); end
    tests++; if (dout !== 16'hBEEF) begin fails++; $display("FAIL ill_dout got %h want beef", dout); end
    tests++; if (bus.DOut !== 16'hBEEF || bus.Err !== 1'b1) begin
      fails++; $display("FAIL ill_hold got %h/%b want beef/1", bus.DOut, bus.Err);
    end
    access(1'b1, 1'b0, 10'h010, 16'h0000, lat, dout, err, rl, bi);
    tests++; if (dout !== 16'h5A5A) begin fails++; $display("FAIL ill_nowrite got %h want 5a5a", dout); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL ill_errclr got %b want 0", err); end
  endtask

  task automatic test_boundary();
    int lat, rl; logic [DW-1:0] dout; logic err, bi;
    access(1'b0, 1'b1, 10'h3FF, 16'h1234, lat, dout, err, rl, bi);
    access(1'b0, 1'b1, 10'h000, 16'hABCD, lat, dout, err, rl, bi);
    access(1'b1, 1'b0, 10'h3FF, 16'h0000, lat, dout, err, rl, bi);
    tests++; if (dout !== 16'h1234) begin fails++; $display("FAIL bound_top got %h want 1234", dout); end
    access(1'b1, 1'b0, 10'h000, 16'h0000, lat, dout, err, rl, bi);
    tests++; if (dout !== 16'hABCD) begin fails++; $display("FAIL bound_bot got %h want abcd", dout); end
  endtask

  task automatic test_held();
    int lat, rl, bad; logic [DW-1:0] dout; logic err, bi;
    @(negedge clk);
    bus.RD = 1'b1; bus.WR = 1'b0; bus.A = 10'h3FF;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (bus.Done !== 1'b1 && lat < Bound);
    tests++; if (lat !== 3) begin fails++; $display("FAIL held_latency got %0d want 3", lat); end
    // Wiggle everything except RD release; nothing may start or complete.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.WR = 1'($urandom); bus.A = 10'h000; bus.DIn = 16'hDEAD;
      @(posedge clk); #1;
      if (bus.Done !== 1'b1 || bus.Busy !== 1'b1 || bus.DOut !== 16'h1234) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL held_stable got %0d bad cycles want 0", bad); end
    @(negedge clk); bus.RD = 1'b0; bus.WR = 1'b0;
    @(posedge clk); #1;
    tests++; if (bus.Done !== 1'b0) begin fails++; $display("FAIL held_release got %b want 0", bus.Done); end
    dout_m = 16'h1234;
    access(1'b1, 1'b0, 10'h000, 16'h0000, lat, dout, err, rl, bi);
    tests++; if (dout !== 16'hABCD) begin fails++; $display("FAIL held_single got %h want abcd", dout); end
  endtask

  task automatic test_input_change();
    int lat, rl; logic [DW-1:0] dout; logic err, bi;
    access(1'b0, 1'b1, 10'h021, 16'h1111, lat, dout, err, rl, bi);
    @(negedge clk);
    bus.WR = 1'b1; bus.RD = 1'b0; bus.A = 10'h020; bus.DIn = 16'h2222;
    @(posedge clk); #1;
    bus.A = 10'h021; bus.DIn = 16'h9999;
    lat = 1;
    do begin @(posedge clk); #1; lat++; end while (bus.Done !== 1'b1 && lat < Bound);
    tests++; if (lat !== 2) begin fails++; $display("FAIL chg_latency got %0d want 2", lat); end
    @(negedge clk); bus.WR = 1'b0;
    repeat (2) @(posedge clk);
    mem_m[32'h020] = 16'h2222;
    access(1'b1, 1'b0, 10'h020, 16'h0000, lat, dout, err, rl, bi);
    tests++; if (dout !== 16'h2222) begin fails++; $display("FAIL chg_target got %h want 2222", dout); end
    access(1'b1, 1'b0, 10'h021, 16'h0000, lat, dout, err, rl, bi);
    tests++; if (dout !== 16'h1111) begin fails++; $display("FAIL chg_other got %h want 1111", dout); end
  endtask

  task automatic test_reset_mid_read();
    int lat, rl;
    @(negedge clk);
    bus.RD = 1'b1; bus.WR = 1'b0; bus.A = 10'h005;
    @(posedge clk); #2;
    ar = 1'b0;
    #1;
    tests++; if (bus.DOut !== '0 || bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
      fails++; $display("FAIL rst_mid got %h/%b/%b want 0/0/0", bus.DOut, bus.Done, bus.Busy);
    end
    dout_m = '0; err_m = 1'b0;
    @(posedge clk);
    @(negedge clk) ar = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (bus.Done !== 1'b1 && lat < Bound);
    tests++; if (lat !== 3) begin fails++; $display("FAIL rst_relat got %0d want 3", lat); end
    tests++; if (bus.DOut !== 16'hBEEF) begin fails++; $display("FAIL rst_redata got %h want beef", bus.DOut); end
    dout_m = 16'hBEEF;
    @(negedge clk); bus.RD = 1'b0;
    rl = 0;
    do begin @(posedge clk); #1; rl++; end while (bus.Done !== 1'b0 && rl < Bound);
  endtask

  task automatic test_back_to_back();
    int lat, rl; logic [DW-1:0] dout; logic err, bi;
    logic [DW-1:0] d;
    d = DW'($urandom);
    access(1'b0, 1'b1, 10'h100, d, lat, dout, err, rl, bi);
    tests++; if (bi !== 1'b0) begin fails++; $display("FAIL b2b_idle got %b want 0", bi); end
    access(1'b1, 1'b0, 10'h100, 16'h0000, lat, dout, err, rl, bi);
    tests++; if (lat !== 3 || dout !== d) begin
      fails++; $display("FAIL b2b_read got %0d/%h want 3/%h", lat, dout, d);
    end
  endtask

  task automatic test_random();
    int lat, rl, exp_lat; logic [DW-1:0] dout; logic err, bi;
    logic [AW-1:0] pool [16];
    logic rd, wr;
    for (int i = 0; i < 16; i++) begin
      pool[i] = AW'($urandom);
      access(1'b0, 1'b1, pool[i], DW'($urandom), lat, dout, err, rl, bi);
    end
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0:       begin rd = 1'b1; wr = 1'b0; end
        1:       begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      exp_lat = (rd && wr) ? 1 : (wr ? 2 : 3);
      access(rd, wr, pool[$urandom_range(0, 15)], DW'($urandom), lat, dout, err, rl, bi);
      tests++; if (lat !== exp_lat) begin fails++; $display("FAIL rnd_lat[%0d] got %0d want %0d", n, lat, exp_lat); end
      tests++; if (dout !== dout_m) begin fails++; $display("FAIL rnd_dout[%0d] got %h want %h", n, dout, dout_m); end
      tests++; if (err !== err_m) begin fails++; $display("FAIL rnd_err[%0d] got %b want %b", n, err, err_m); end
      tests++; if (rl !== 1 || bi !== 1'b0) begin
        fails++; $display("FAIL rnd_release[%0d] got %0d/%b want 1/0", n, rl, bi);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_illegal();
    test_boundary();
    test_held();
    test_input_change();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
